// File: rtl/collision_scanner.sv
// collision_scanner: scans the object table once per frame and reports Mario's edge contacts and the first coin eaten.
module collision_scanner #(
    parameter int          OBJ_COUNT  = 16,
    parameter logic [9:0]  MONEY_TYPE = 10'd2,
    localparam int         IW         = $clog2(OBJ_COUNT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Frame_Start,
    input  logic [31:0]   Mario_Coordinate,
    input  logic [31:0]   Mario_Size,
    output logic [IW-1:0] Obj_Index,
    input  logic [31:0]   Obj_Coordinate,
    input  logic [31:0]   Obj_Size,
    input  logic [9:0]    Obj_Type,
    input  logic          Obj_Collision_Enable,
    output logic [3:0]    Collision,
    output logic [10:0]   Collision_Type,
    output logic [9:0]    Mario_Signal,
    output logic          Consume_Valid,
    output logic [IW-1:0] Consume_Index,
    output logic          Busy,
    output logic          Done
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, cmp_idx_q, cmp_idx_d, coin_idx_q, coin_idx_d, ci_q, ci_d;
    logic          cmp_valid_q, cmp_valid_d, hit_q, hit_d, coin_hit_q, coin_hit_d;
    logic          coin_pulse_q, coin_pulse_d, done_q, done_d;
    logic [9:0]    mx_q, mx_d, my_q, my_d, mw_q, mw_d, ml_q, ml_d, type_acc_q, type_acc_d;
    logic [3:0]    coll_acc_q, coll_acc_d, coll_q, coll_d, dir;
    logic [10:0]   ctype_q, ctype_d, m_r, m_b, o_r, o_b;
    logic [9:0]    ox, oy, ow, ol;
    logic          start, last, pub, valid_obj, h, v, ovl, contact, coin;
    logic          unused;
    assign unused = ^{Mario_Coordinate[31:26], Mario_Coordinate[15:10], Mario_Size[31:26], Mario_Size[15:10],
                      Obj_Coordinate[31:26], Obj_Coordinate[15:10], Obj_Size[31:26], Obj_Size[15:10]};
    always_comb begin
        ox = Obj_Coordinate[25:16];
        oy = Obj_Coordinate[9:0];
        ow = Obj_Size[25:16];
        ol = Obj_Size[9:0];
        m_r = {1'b0, mx_q} + {1'b0, mw_q};
        m_b = {1'b0, my_q} + {1'b0, ml_q};
        o_r = {1'b0, ox} + {1'b0, ow};
        o_b = {1'b0, oy} + {1'b0, ol};
        h = ({1'b0, mx_q} < o_r) && ({1'b0, ox} < m_r);
        v = ({1'b0, my_q} < o_b) && ({1'b0, oy} < m_b);
        valid_obj = cmp_valid_q && Obj_Collision_Enable && ow != '0 && ol != '0;
        // Edge equality excludes overlap on that axis, so a corner touch yields no direction bit
        dir = {h && o_b == {1'b0, my_q}, h && {1'b0, oy} == m_b,
               v && o_r == {1'b0, mx_q}, v && {1'b0, ox} == m_r} & {4{valid_obj}};
        ovl = valid_obj && h && v;
        contact = (|dir) || ovl;
        coin = ovl && Obj_Type == MONEY_TYPE;
        start = state_q == IDLE && Frame_Start;
        last = idx_q == IW'(OBJ_COUNT - 1);
        pub = state_q == DRAIN;
        state_d = start ? SCAN : (state_q == SCAN && last) ? DRAIN : pub ? IDLE : state_q;
        idx_d = (state_q == SCAN && !last) ? idx_q + 1'b1 : '0;
        cmp_valid_d = state_q == SCAN;
        cmp_idx_d = idx_q;
        mx_d = start ? Mario_Coordinate[25:16] : mx_q;
        my_d = start ? Mario_Coordinate[9:0] : my_q;
        mw_d = start ? Mario_Size[25:16] : mw_q;
        ml_d = start ? Mario_Size[9:0] : ml_q;
        coll_acc_d = start ? '0 : coll_acc_q | dir;
        hit_d = !start && (hit_q || contact);
        type_acc_d = start ? '0 : (!hit_q && contact) ? Obj_Type : type_acc_q;
        coin_hit_d = !start && (coin_hit_q || coin);
        coin_idx_d = start ? '0 : (!coin_hit_q && coin) ? cmp_idx_q : coin_idx_q;
        // The last object's compare merges straight into the published result
        coll_d = pub ? coll_acc_d : coll_q;
        ctype_d = pub ? {1'b0, type_acc_d} : ctype_q;
        coin_pulse_d = pub && coin_hit_d;
        ci_d = pub ? coin_idx_d : '0;
        done_d = pub;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q <= '0;
            cmp_idx_q <= '0;
            cmp_valid_q <= 1'b0;
            mx_q <= '0;
            my_q <= '0;
            mw_q <= '0;
            ml_q <= '0;
            coll_acc_q <= '0;
            hit_q <= 1'b0;
            type_acc_q <= '0;
            coin_hit_q <= 1'b0;
            coin_idx_q <= '0;
            coll_q <= '0;
            ctype_q <= '0;
            coin_pulse_q <= 1'b0;
            ci_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            cmp_idx_q <= cmp_idx_d;
            cmp_valid_q <= cmp_valid_d;
            mx_q <= mx_d;
            my_q <= my_d;
            mw_q <= mw_d;
            ml_q <= ml_d;
            coll_acc_q <= coll_acc_d;
            hit_q <= hit_d;
            type_acc_q <= type_acc_d;
            coin_hit_q <= coin_hit_d;
            coin_idx_q <= coin_idx_d;
            coll_q <= coll_d;
            ctype_q <= ctype_d;
            coin_pulse_q <= coin_pulse_d;
            ci_q <= ci_d;
            done_q <= done_d;
        end
    end
    assign Obj_Index = idx_q;
    assign Collision = coll_q;
    assign Collision_Type = ctype_q;
    assign Mario_Signal = {9'b0, coin_pulse_q};
    assign Consume_Valid = coin_pulse_q;
    assign Consume_Index = ci_q;
    assign Busy = state_q != IDLE;
    assign Done = done_q;
endmodule

// File: tb/tb_collision_scanner.sv
// tb_collision_scanner: directed frames against a registered object-table model with hand-computed results.
module tb_collision_scanner;
    localparam int IW = 4;
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          Frame_Start = 1'b0;
    logic [31:0]   Mario_Coordinate = '0, Mario_Size = '0;
    logic [IW-1:0] Obj_Index;
    logic [31:0]   Obj_Coordinate = '0, Obj_Size = '0;
    logic [9:0]    Obj_Type = '0;
    logic          Obj_Collision_Enable = 1'b0;
    logic [3:0]    Collision;
    logic [10:0]   Collision_Type;
    logic [9:0]    Mario_Signal;
    logic          Consume_Valid, Busy, Done;
    logic [IW-1:0] Consume_Index;
    logic [31:0]   tbl_c [16];
    logic [31:0]   tbl_s [16];
    logic [9:0]    tbl_t [16];
    logic          tbl_e [16];
    int            n_checks = 0, n_fail = 0;
    int            done_at, done_cnt, cv_cnt, idx_err;
    logic          busy1, busy17, busy18, fin_busy;
    logic [3:0]    cap_coll, fin_coll;
    logic [10:0]   cap_type, fin_type;
    logic [9:0]    cap_sig, fin_sig;
    logic          cap_cv;
    logic [IW-1:0] cap_ci;

    collision_scanner dut (
        .clk(clk), .rst(rst), .Frame_Start(Frame_Start),
        .Mario_Coordinate(Mario_Coordinate), .Mario_Size(Mario_Size),
        .Obj_Index(Obj_Index), .Obj_Coordinate(Obj_Coordinate), .Obj_Size(Obj_Size),
        .Obj_Type(Obj_Type), .Obj_Collision_Enable(Obj_Collision_Enable),
        .Collision(Collision), .Collision_Type(Collision_Type), .Mario_Signal(Mario_Signal),
        .Consume_Valid(Consume_Valid), .Consume_Index(Consume_Index), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    // Object table with one-cycle registered read
    always @(posedge clk) begin
        Obj_Coordinate <= tbl_c[Obj_Index];
        Obj_Size <= tbl_s[Obj_Index];
        Obj_Type <= tbl_t[Obj_Index];
        Obj_Collision_Enable <= tbl_e[Obj_Index];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < 16; i++) begin
            tbl_c[i] = '0;
            tbl_s[i] = '0;
            tbl_t[i] = '0;
            tbl_e[i] = 1'b0;
        end
    endtask

    task automatic set_obj(input int i, input int x, input int y, input int w, input int l, input int ty, input logic en);
        tbl_c[i] = {6'd0, 10'(x), 6'd0, 10'(y)};
        tbl_s[i] = {6'd0, 10'(w), 6'd0, 10'(l)};
        tbl_t[i] = 10'(ty);
        tbl_e[i] = en;
    endtask

    // Cycle lat = t+lat after the edge that samples Frame_Start; Mario input is scrambled to prove it was latched
    task automatic run_frame(input int restart_at, input int abort_at);
        logic [31:0] mc;
        mc = Mario_Coordinate;
        done_at = 0;
        done_cnt = 0;
        cv_cnt = 0;
        idx_err = 0;
        @(negedge clk);
        Frame_Start = 1'b1;
        for (int lat = 1; lat <= 24; lat++) begin
            @(negedge clk);
            if (Done) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = lat;
                    cap_coll = Collision;
                    cap_type = Collision_Type;
                    cap_sig = Mario_Signal;
                    cap_cv = Consume_Valid;
                    cap_ci = Consume_Index;
                end
            end
            if (Consume_Valid) cv_cnt++;
            if (abort_at == 0 && lat <= 16 && Obj_Index != IW'(lat - 1)) idx_err++;
            if (lat == 1) busy1 = Busy;
            if (lat == 17) busy17 = Busy;
            if (lat == 18) busy18 = Busy;
            Frame_Start = (lat == restart_at) || (abort_at != 0 && lat == abort_at + 1);
            rst = !(abort_at != 0 && (lat == abort_at || lat == abort_at + 1));
            Mario_Coordinate = '0;
        end
        fin_busy = Busy;
        fin_coll = Collision;
        fin_type = Collision_Type;
        fin_sig = Mario_Signal;
        Frame_Start = 1'b0;
        rst = 1'b1;
        Mario_Coordinate = mc;
    endtask

    task automatic frame_checks(input logic [3:0] c, input logic [10:0] ty, input logic coin, input logic [IW-1:0] ci);
        check("done_at", done_at, 18);
        check("done_cnt", done_cnt, 1);
        check("busy_t1", busy1, 1);
        check("busy_t17", busy17, 1);
        check("busy_t18", busy18, 0);
        check("idx_seq_err", idx_err, 0);
        check("collision", cap_coll, c);
        check("coll_type", cap_type, ty);
        check("mario_sig", cap_sig, {9'b0, coin});
        check("consume_valid", cap_cv, coin);
        check("consume_idx", cap_ci, coin ? ci : '0);
        check("consume_pulses", cv_cnt, coin ? 1 : 0);
        check("coll_held", fin_coll, c);
        check("type_held", fin_type, ty);
        check("sig_dropped", fin_sig, 0);
    endtask

    initial begin
        clear_tbl();
        Mario_Coordinate = {6'd0, 10'd100, 6'd0, 10'd200};
        Mario_Size = {6'd0, 10'd25, 6'd0, 10'd40};
        repeat (3) @(negedge clk);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_coll", Collision, 0);
        check("rst_type", Collision_Type, 0);
        check("rst_sig", Mario_Signal, 0);
        check("rst_cv", Consume_Valid, 0);
        check("rst_ci", Consume_Index, 0);
        check("rst_idx", Obj_Index, 0);
        rst = 1'b1;
        @(negedge clk);

        set_obj(0, 90, 240, 50, 20, 1, 1'b1);
        run_frame(0, 0);
        frame_checks(4'b0100, 11'd1, 1'b0, '0);

        clear_tbl();
        set_obj(2, 100, 180, 10, 20, 3, 1'b1);
        set_obj(4, 80, 200, 20, 10, 6, 1'b1);
        set_obj(12, 105, 205, 5, 5, 7, 1'b1);
        run_frame(0, 0);
        frame_checks(4'b1010, 11'd3, 1'b0, '0);

        clear_tbl();
        set_obj(3, 125, 210, 10, 10, 4, 1'b1);
        set_obj(7, 60, 100, 40, 100, 5, 1'b1);
        run_frame(0, 0);
        frame_checks(4'b0001, 11'd4, 1'b0, '0);

        set_obj(7, 60, 100, 40, 150, 5, 1'b1);
        run_frame(0, 0);
        frame_checks(4'b0011, 11'd4, 1'b0, '0);

        clear_tbl();
        set_obj(5, 110, 210, 8, 8, 2, 1'b1);
        set_obj(9, 105, 205, 8, 8, 2, 1'b1);
        run_frame(0, 0);
        frame_checks(4'b0000, 11'd2, 1'b1, 4'd5);

        clear_tbl();
        set_obj(0, 90, 240, 50, 20, 1, 1'b0);
        run_frame(0, 0);
        frame_checks(4'b0000, 11'd0, 1'b0, '0);

        set_obj(0, 90, 240, 0, 20, 1, 1'b1);
        run_frame(0, 0);
        frame_checks(4'b0000, 11'd0, 1'b0, '0);

        set_obj(0, 90, 240, 50, 20, 1, 1'b1);
        run_frame(5, 0);
        frame_checks(4'b0100, 11'd1, 1'b0, '0);

        run_frame(0, 10);
        check("abort_done_cnt", done_cnt, 0);
        check("abort_busy", fin_busy, 0);
        check("abort_coll", fin_coll, 0);
        check("abort_type", fin_type, 0);
        check("abort_sig", fin_sig, 0);

        run_frame(0, 0);
        frame_checks(4'b0100, 11'd1, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
